stim_sequencer: RTL and testbench
=================================

Name: stim_sequencer

Overview:
- Synthesizable, parametrised stimulus sequencer for simulation harnesses. Replaces hand-written `#delay` stimulus blocks.
- Drives a DUT reset plus CHANNELS stimulus lines from a small writable schedule: a reset phase first, then a list of (pattern, hold-cycles) steps.
- Ends with a one-cycle done pulse, or loops over the schedule.
- Behaviour is deterministic in Verilator and event-driven simulators: all timing is in clock cycles, with no delays.

Parameters:
- CHANNELS, 4, number of stimulus output lines.
- DEPTH, 8, number of schedule entries.
- HOLD_W, 8, width of the per-step hold count.
- RST_CYCLES, 1, cycles dut_rst stays asserted after start, before step 0; minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  schedule write strobe.
- wr_addr  in  $clog2(DEPTH)  schedule entry index.
- wr_pattern  in  CHANNELS  pattern to store.
- wr_hold  in  HOLD_W  hold count to store.
- start  in  1  begin a run; honoured only in IDLE.
- num_steps  in  $clog2(DEPTH)+1  steps per pass; sampled with start.
- loop_en  in  1  repeat the schedule; sampled with start.
- stop  in  1  abort the run.
- dut_rst  out  1  reset driven to the DUT.
- stim  out  CHANNELS  current stimulus pattern.
- step_idx  out  $clog2(DEPTH)  index of the active step.
- trace_valid  out  1  one-cycle pulse on every step load.
- busy  out  1  high in RESET_PHASE and RUN.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - state IDLE.
  - dut_rst=1; stim=0; step_idx=0.
  - trace_valid=0; busy=0; done=0.
  - All schedule entries cleared to pattern 0, hold 0.
- Schedule writes:
  - On wr_en, entry[wr_addr] takes {wr_pattern, wr_hold} at the clock edge. Writes are accepted in any state.
  - An entry is read when its step is loaded, so a write takes effect on the entry's next load.
  - Same-cycle write and load of the same entry: the load uses the old contents.
- Effective hold per step is max(hold,1) cycles.
- Effective step count n = min(num_steps, DEPTH).
- States:
  - IDLE:
    - Outputs: dut_rst=1, stim=0, busy=0.
    - start with n>0 -> RESET_PHASE.
    - start with n=0 -> DONE.
  - RESET_PHASE:
    - Outputs: dut_rst=1, stim=0, busy=1.
    - Lasts exactly RST_CYCLES cycles, then -> RUN and loads step 0.
  - RUN:
    - Outputs: dut_rst=0, busy=1, stim=entry[step_idx].pattern.
    - On each step load: trace_valid=1 for that first cycle, and the hold counter is loaded.
    - After the final hold cycle of step k:
      - k<n-1: load step k+1.
      - k=n-1 and loop_en: load step 0 with no new reset phase, and trace_valid pulses.
      - k=n-1 and not loop_en: -> DONE.
  - DONE:
    - Outputs: done=1, dut_rst=1, stim=0, busy=0 for exactly one cycle.
    - Then -> IDLE.
- Timing from start:
  - start sampled high at edge T (state IDLE).
  - From T+1: busy=1 and dut_rst=1.
  - At T+1+RST_CYCLES: dut_rst=0 and stim=entry[0].pattern.
- stop:
  - stop high in RESET_PHASE or RUN -> IDLE on the next edge.
  - IDLE outputs apply; no done pulse.
  - stop has priority over all step advances.
  - stop in IDLE or DONE is ignored.
- start outside IDLE is ignored. In DONE, start is ignored; it must be reissued in IDLE.
- rst has priority over everything. rst mid-run returns all outputs to reset values on the next edge and clears the schedule.
- step_idx wraps only through the loop path; it never exceeds n-1.
- Hold counter: HOLD_W bits, counts down to 1. A hold of 2^HOLD_W-1 must be supported.

Test Plan:
- Baseline: CHANNELS=4, RST_CYCLES=1; entry0={4'b0010,1}; start at T with num_steps=1, loop_en=0.
  - dut_rst=1 at T+1, then 0 at T+2.
  - stim=4'b0010 at T+2 only.
  - done=1 at T+3; dut_rst=1 again at T+3.
- Multi-step holds: entries {4'h1,3},{4'h8,0},{4'hF,2}; num_steps=3.
  - stim sequence after reset: 1,1,1,8,F,F; hold 0 is treated as 1.
  - trace_valid pulses on exactly 3 cycles.
  - done follows the last F by one cycle.
- Loop and stop: the same schedule with loop_en=1.
  - After F,F the sequence returns to 1 with dut_rst staying 0.
  - stop asserted mid-step 1 -> next cycle stim=0, dut_rst=1, busy=0, and done never pulses.
- Edge counts:
  - num_steps=0 -> done at T+1, busy never high.
  - num_steps=12 with DEPTH=8 -> exactly 8 steps run.
  - start while busy is ignored, with no restart of the reset phase.
- Live write and reset:
  - Rewrite entry 2 to {4'h5,1} during step 0 -> step 2 drives 5.
  - Assert rst during RUN -> next cycle dut_rst=1, stim=0, and entries read back as 0 on a subsequent run.

Source files
------------

// File: rtl/stim_sequencer_if.sv
// Command and status bundle between a harness controller and the stimulus sequencer.
interface stim_sequencer_if #(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 8,
    parameter int HOLD_W   = 8
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH) + 1;

    logic                wr_en;
    logic [IW-1:0]       wr_addr;
    logic [CHANNELS-1:0] wr_pattern;
    logic [HOLD_W-1:0]   wr_hold;
    logic                start;
    logic [NW-1:0]       num_steps;
    logic                loop_en;
    logic                stop;
    logic                dut_rst;
    logic [CHANNELS-1:0] stim;
    logic [IW-1:0]       step_idx;
    logic                trace_valid;
    logic                busy;
    logic                done;

    modport master (
        output wr_en, wr_addr, wr_pattern, wr_hold, start, num_steps, loop_en, stop,
        input  dut_rst, stim, step_idx, trace_valid, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_pattern, wr_hold, start, num_steps, loop_en, stop,
        output dut_rst, stim, step_idx, trace_valid, busy, done
    );
endinterface

// File: rtl/stim_sequencer.sv
// Cycle-accurate stimulus sequencer: reset phase, then a writable list of
// (pattern, hold) steps, ending in a done pulse or looping over the schedule.
module stim_sequencer #(
    parameter int CHANNELS   = 4,
    parameter int DEPTH      = 8,
    parameter int HOLD_W     = 8,
    parameter int RST_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    stim_sequencer_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH) + 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RESET_PHASE, RUN, DONE} state_t;

    state_t              state, state_n;
    logic [RW-1:0]       rst_cnt, rst_cnt_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
    logic [IW-1:0]       idx, idx_n;
    logic [NW-1:0]       n_steps, n_steps_n;
    logic                loop_r, loop_n;
    logic                load;
    logic [IW-1:0]       load_idx;
    logic [CHANNELS-1:0] stim_n;
    logic [NW-1:0]       eff_steps;
    logic                last_step;

    logic [CHANNELS-1:0] pat_mem  [DEPTH];
    logic [HOLD_W-1:0]   hold_mem [DEPTH];

    logic                dut_rst_r, trace_r, busy_r, done_r;
    logic [CHANNELS-1:0] stim_r;

    assign eff_steps = (bus.num_steps > NW'(DEPTH)) ? NW'(DEPTH) : bus.num_steps;
    assign last_step = (NW'(idx) == (n_steps - NW'(1)));

    // Next-state, step sequencing and the pattern that the output register takes next.
    always_comb begin
        state_n    = state;
        rst_cnt_n  = rst_cnt;
        hold_cnt_n = hold_cnt;
        idx_n      = idx;
        n_steps_n  = n_steps;
        loop_n     = loop_r;
        load       = 1'b0;
        load_idx   = '0;
        stim_n     = '0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    n_steps_n = eff_steps;
                    loop_n    = bus.loop_en;
                    rst_cnt_n = RW'(RST_CYCLES - 1);
                    state_n   = (eff_steps == '0) ? DONE : RESET_PHASE;
                end
            end
            RESET_PHASE: begin
                if (rst_cnt == '0) begin
                    state_n  = RUN;
                    load     = 1'b1;
                    load_idx = '0;
                end else begin
                    rst_cnt_n = rst_cnt - RW'(1);
                end
            end
            RUN: begin
                if (hold_cnt == HOLD_W'(1)) begin
                    if (!last_step) begin
                        load     = 1'b1;
                        load_idx = idx + IW'(1);
                    end else if (loop_r) begin
                        load     = 1'b1;
                        load_idx = '0;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    hold_cnt_n = hold_cnt - HOLD_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (bus.stop && (state == RESET_PHASE || state == RUN)) begin
            state_n = IDLE;
            load    = 1'b0;
        end

        if (load) begin
            idx_n      = load_idx;
            hold_cnt_n = (hold_mem[load_idx] == '0) ? HOLD_W'(1) : hold_mem[load_idx];
            stim_n     = pat_mem[load_idx];
        end else if (state_n == RUN) begin
            stim_n = stim_r;
        end

        if (state_n != RUN) begin
            idx_n = '0;
        end
    end

    // State, schedule storage and registered outputs; rst clears everything including the schedule.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rst_cnt   <= '0;
            hold_cnt  <= '0;
            idx       <= '0;
            n_steps   <= '0;
            loop_r    <= 1'b0;
            dut_rst_r <= 1'b1;
            stim_r    <= '0;
            trace_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pat_mem[i]  <= '0;
                hold_mem[i] <= '0;
            end
        end else begin
            state     <= state_n;
            rst_cnt   <= rst_cnt_n;
            hold_cnt  <= hold_cnt_n;
            idx       <= idx_n;
            n_steps   <= n_steps_n;
            loop_r    <= loop_n;
            dut_rst_r <= (state_n != RUN);
            stim_r    <= stim_n;
            trace_r   <= load;
            busy_r    <= (state_n == RESET_PHASE) || (state_n == RUN);
            done_r    <= (state_n == DONE);
            if (bus.wr_en && (int'(bus.wr_addr) < DEPTH)) begin
                pat_mem[bus.wr_addr]  <= bus.wr_pattern;
                hold_mem[bus.wr_addr] <= bus.wr_hold;
            end
        end
    end

    assign bus.dut_rst     = dut_rst_r;
    assign bus.stim        = stim_r;
    assign bus.step_idx    = idx;
    assign bus.trace_valid = trace_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
endmodule

// File: tb/tb_stim_sequencer.sv
// Self-checking bench for stim_sequencer: a schedule model expands each run
// into the expected per-cycle output vector and every cycle is compared.
module tb_stim_sequencer;
    localparam int CHANNELS = 4;
    localparam int DEPTH    = 8;
    localparam int HOLD_W   = 8;
    localparam int RC       = 1;
    localparam logic [10:0] IDLE_VEC = 11'h400;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [3:0]  m_pat  [DEPTH];
    int          m_hold [DEPTH];
    logic [10:0] exp_q [$];

    stim_sequencer_if #(.CHANNELS(CHANNELS), .DEPTH(DEPTH), .HOLD_W(HOLD_W)) bus ();

    stim_sequencer #(
        .CHANNELS(CHANNELS), .DEPTH(DEPTH), .HOLD_W(HOLD_W), .RST_CYCLES(RC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Vector layout: {dut_rst, busy, done, trace_valid, step_idx[2:0], stim[3:0]}
    function automatic logic [10:0] vec(bit dr, bit bz, bit dn, bit tr, int k, logic [3:0] s);
        return {dr, bz, dn, tr, 3'(k), s};
    endfunction

    function automatic logic [10:0] observed();
        return {bus.dut_rst, bus.busy, bus.done, bus.trace_valid, bus.step_idx, bus.stim};
    endfunction

    // step_idx only matters while the DUT is out of reset
    function automatic logic [10:0] mask_for(logic [10:0] e);
        return e[10] ? 11'h78F : 11'h7FF;
    endfunction

    task automatic build_expect(int nsteps, bit loop, int passes);
        int n;
        n = (nsteps > DEPTH) ? DEPTH : nsteps;
        exp_q.delete();
        if (n == 0) begin
            exp_q.push_back(vec(1, 0, 1, 0, 0, 4'h0));
            return;
        end
        repeat (RC) exp_q.push_back(vec(1, 1, 0, 0, 0, 4'h0));
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < n; k++) begin
                int h;
                h = (m_hold[k] == 0) ? 1 : m_hold[k];
                for (int c = 0; c < h; c++)
                    exp_q.push_back(vec(0, 1, 0, (c == 0), k, m_pat[k]));
            end
        end
        if (!loop) exp_q.push_back(vec(1, 0, 1, 0, 0, 4'h0));
    endtask

    task automatic write_entry(int addr, logic [3:0] pat, int hold);
        @(negedge clk);
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 3'(addr);
        bus.wr_pattern = pat;
        bus.wr_hold    = HOLD_W'(hold);
        m_pat[addr]    = pat;
        m_hold[addr]   = hold;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            m_pat[i]  = 4'h0;
            m_hold[i] = 0;
        end
    endtask

    // Leaves the bench at the sampling point of the first cycle after start was taken
    task automatic start_run(int n, bit loop);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.num_steps = 4'(n);
        bus.loop_en   = loop;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ((observed() & 11'h78F) !== IDLE_VEC) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got %h expected %h", observed(), IDLE_VEC);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ((observed() & 11'h78F) !== IDLE_VEC) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got %h expected %h", observed(), IDLE_VEC);
        end
    endtask

    task automatic test_baseline();
        write_entry(0, 4'b0010, 1);
        build_expect(1, 0, 1);
        start_run(1, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if ((observed() & mask_for(exp_q[i])) !== (exp_q[i] & mask_for(exp_q[i]))) begin
                n_fail++;
                $display("[TB] FAIL baseline cycle T+%0d: got %h expected %h", i + 1, observed(), exp_q[i]);
            end
            @(negedge clk);
        end
        n_checks++;
        if ((observed() & 11'h78F) !== IDLE_VEC) begin
            n_fail++;
            $display("[TB] FAIL baseline_idle: got %h expected %h", observed(), IDLE_VEC);
        end
    endtask

    task automatic test_multi_step();
        int traces;
        traces = 0;
        write_entry(0, 4'h1, 3);
        write_entry(1, 4'h8, 0);
        write_entry(2, 4'hF, 2);
        build_expect(3, 0, 1);
        start_run(3, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (bus.trace_valid === 1'b1) traces++;
            if ((observed() & mask_for(exp_q[i])) !== (exp_q[i] & mask_for(exp_q[i]))) begin
                n_fail++;
                $display("[TB] FAIL multi_step cycle %0d: got %h expected %h", i + 1, observed(), exp_q[i]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (traces != 3) begin
            n_fail++;
            $display("[TB] FAIL multi_step_traces: got %0d expected 3", traces);
        end
    endtask

    task automatic test_loop_stop();
        int stop_at;
        write_entry(0, 4'h1, 3);
        write_entry(1, 4'h8, 0);
        write_entry(2, 4'hF, 2);
        build_expect(3, 1, 3);
        stop_at = RC + 2 * 6 + 3;
        start_run(3, 1);
        for (int i = 0; i <= stop_at; i++) begin
            n_checks++;
            if ((observed() & mask_for(exp_q[i])) !== (exp_q[i] & mask_for(exp_q[i]))) begin
                n_fail++;
                $display("[TB] FAIL loop cycle %0d: got %h expected %h", i + 1, observed(), exp_q[i]);
            end
            if (i == stop_at) bus.stop = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if ((observed() & 11'h78F) !== IDLE_VEC) begin
            n_fail++;
            $display("[TB] FAIL stop_to_idle: got %h expected %h", observed(), IDLE_VEC);
        end
        bus.stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if ((observed() & 11'h78F) !== IDLE_VEC) begin
                n_fail++;
                $display("[TB] FAIL stop_no_done %0d: got %h expected %h", i, observed(), IDLE_VEC);
            end
        end
    endtask

    task automatic test_edge_counts();
        int traces;
        build_expect(0, 0, 1);
        start_run(0, 0);
        n_checks++;
        if (observed() !== exp_q[0] && (observed() & 11'h78F) !== (exp_q[0] & 11'h78F)) begin
            n_fail++;
            $display("[TB] FAIL zero_steps_done: got %h expected %h", observed(), exp_q[0]);
        end
        @(negedge clk);
        n_checks++;
        if ((observed() & 11'h78F) !== IDLE_VEC) begin
            n_fail++;
            $display("[TB] FAIL zero_steps_idle: got %h expected %h", observed(), IDLE_VEC);
        end

        for (int a = 0; a < DEPTH; a++) write_entry(a, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        build_expect(12, 0, 1);
        traces = 0;
        start_run(12, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (bus.trace_valid === 1'b1) traces++;
            if ((observed() & mask_for(exp_q[i])) !== (exp_q[i] & mask_for(exp_q[i]))) begin
                n_fail++;
                $display("[TB] FAIL clamp_steps cycle %0d: got %h expected %h", i + 1, observed(), exp_q[i]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (traces != DEPTH) begin
            n_fail++;
            $display("[TB] FAIL clamp_steps_traces: got %0d expected %0d", traces, DEPTH);
        end

        write_entry(0, 4'hA, 255);
        build_expect(1, 0, 1);
        start_run(1, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if ((observed() & mask_for(exp_q[i])) !== (exp_q[i] & mask_for(exp_q[i]))) begin
                n_fail++;
                $display("[TB] FAIL max_hold cycle %0d: got %h expected %h", i + 1, observed(), exp_q[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        write_entry(0, 4'h3, 2);
        write_entry(1, 4'hC, 1);
        write_entry(2, 4'h6, 2);
        build_expect(3, 0, 1);
        start_run(3, 0);
        bus.start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if ((observed() & mask_for(exp_q[i])) !== (exp_q[i] & mask_for(exp_q[i]))) begin
                n_fail++;
                $display("[TB] FAIL start_while_busy cycle %0d: got %h expected %h", i + 1, observed(), exp_q[i]);
            end
            @(negedge clk);
        end
        n_checks++;
        if ((observed() & 11'h78F) !== IDLE_VEC) begin
            n_fail++;
            $display("[TB] FAIL start_in_done: got %h expected %h", observed(), IDLE_VEC);
        end
        bus.start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ((observed() & 11'h78F) !== IDLE_VEC) begin
            n_fail++;
            $display("[TB] FAIL start_in_done_idle: got %h expected %h", observed(), IDLE_VEC);
        end
    endtask

    task automatic test_live_write();
        write_entry(0, 4'h1, 3);
        write_entry(1, 4'h8, 0);
        write_entry(2, 4'hF, 2);
        m_pat[2]  = 4'h5;
        m_hold[2] = 1;
        build_expect(3, 0, 1);
        start_run(3, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if ((observed() & mask_for(exp_q[i])) !== (exp_q[i] & mask_for(exp_q[i]))) begin
                n_fail++;
                $display("[TB] FAIL live_write cycle %0d: got %h expected %h", i + 1, observed(), exp_q[i]);
            end
            if (i == RC) begin
                bus.wr_en      = 1'b1;
                bus.wr_addr    = 3'd2;
                bus.wr_pattern = 4'h5;
                bus.wr_hold    = 8'd1;
            end else if (i == RC + 1) begin
                bus.wr_en = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < DEPTH; a++) write_entry(a, 4'($urandom_range(0, 15)), $urandom_range(0, 4));
            n = $urandom_range(1, DEPTH);
            build_expect(n, 0, 1);
            start_run(n, 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if ((observed() & mask_for(exp_q[i])) !== (exp_q[i] & mask_for(exp_q[i]))) begin
                    n_fail++;
                    $display("[TB] FAIL random it%0d cycle %0d: got %h expected %h", it, i + 1, observed(), exp_q[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_rst_mid_run();
        for (int a = 0; a < 3; a++) write_entry(a, 4'($urandom_range(1, 15)), 2);
        build_expect(3, 0, 1);
        start_run(3, 0);
        for (int i = 0; i <= RC + 1; i++) begin
            n_checks++;
            if ((observed() & mask_for(exp_q[i])) !== (exp_q[i] & mask_for(exp_q[i]))) begin
                n_fail++;
                $display("[TB] FAIL pre_rst cycle %0d: got %h expected %h", i + 1, observed(), exp_q[i]);
            end
            if (i == RC + 1) rst = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if ((observed() & 11'h78F) !== IDLE_VEC) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_run: got %h expected %h", observed(), IDLE_VEC);
        end
        rst = 1'b0;
        clear_model();
        build_expect(3, 0, 1);
        start_run(3, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if ((observed() & mask_for(exp_q[i])) !== (exp_q[i] & mask_for(exp_q[i]))) begin
                n_fail++;
                $display("[TB] FAIL cleared_schedule cycle %0d: got %h expected %h", i + 1, observed(), exp_q[i]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_pattern = '0;
        bus.wr_hold    = '0;
        bus.start      = 1'b0;
        bus.num_steps  = '0;
        bus.loop_en    = 1'b0;
        bus.stop       = 1'b0;
        clear_model();
        test_reset();
        test_baseline();
        test_multi_step();
        test_loop_stop();
        test_edge_counts();
        test_back_to_back();
        test_live_write();
        test_random();
        test_rst_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
